im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit instruction-memory words.
REQ-002 Parameter: ADDR_W, 10, write-address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  single-cycle pulse that begins a program load.
REQ-006 Port: in_valid  input  1  byte-stream data valid.
REQ-007 Port: in_byte  input  8  byte-stream data.
REQ-008 Port: in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready on a clock edge.
REQ-009 Port: wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port: wr_addr  output  ADDR_W  instruction-memory word address.
REQ-011 Port: wr_data  output  32  instruction word.
REQ-012 Port: busy  output  1  load in progress; high in every state except IDLE, DONE and ERR.
REQ-013 Port: done  output  1  sticky; load completed successfully.
REQ-014 Port: error  output  1  sticky; load aborted.

Function
REQ-015 The FSM SHALL use states IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE and ERR.
REQ-016 start in IDLE, DONE or ERR SHALL clear done, error, the address counter and the byte counter, then enter HDR_HI; start in any other state SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in HDR_HI, HDR_LO, DATA and CHK.
REQ-018 HDR_HI/HDR_LO SHALL capture a 16-bit big-endian word count N (HI byte first), one byte per transfer.
REQ-019 After HDR_LO: N==0 -> DONE; N>DEPTH -> ERR with no write; otherwise -> DATA.
REQ-020 DATA SHALL assemble each word big-endian: 1st byte -> bits 31:24, 4th byte -> bits 7:0.
REQ-021 After the 4th byte is accepted, the FSM SHALL enter WRITE; during WRITE, wr_en=1 for exactly one cycle with wr_data = the assembled word and wr_addr = the current word index.
REQ-022 The first word SHALL be written to address 0; the address SHALL increment by 1 after each write and never wrap, since N<=DEPTH.
REQ-023 After the write of word N-1, the FSM SHALL enter CHK (macro defined) or DONE (macro undefined); otherwise it SHALL return to DATA.
REQ-024 Bytes presented while in_ready=0 SHALL not be consumed, and gaps in in_valid SHALL stall without state change.
REQ-025 Minimum throughput SHALL be 5 cycles per word: 4 byte transfers plus 1 WRITE cycle.
REQ-026 wr_en SHALL be 0 in all states other than WRITE.
REQ-027 wr_data and wr_addr SHALL hold their last values when wr_en=0.
REQ-028 DONE SHALL set done=1; ERR SHALL set error=1; both SHALL persist until start or reset.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and set in_ready, wr_en, busy, done and error to 0, wr_addr to 0, wr_data to 0, and all counters and the word count to 0.
REQ-030 Reset asserted mid-load SHALL abort the load with no further write, and the FSM SHALL remain in IDLE after release until start.

Configuration
REQ-031 With IM_LOADER_CHECKSUM_EN defined, the loader SHALL keep a running XOR of all data bytes (header excluded) and accept one checksum byte in CHK: equal -> DONE, unequal -> ERR; writes already performed SHALL stand.
REQ-032 Without IM_LOADER_CHECKSUM_EN, CHK SHALL be unreachable, no checksum logic SHALL exist, and the load SHALL end in DONE after the last write.

Verification
REQ-033 start; bytes 00 02 12 34 56 78 DE AD BE EF, in_valid continuous -> writes addr0=0x12345678, addr1=0xDEADBEEF, 5 cycles apart; done=1, error=0.
REQ-034 start; header 00 00 -> no wr_en; done=1 the cycle after HDR_LO; busy=0.
REQ-035 start; header 04 01 (1025 > DEPTH) -> error=1, done=0, zero writes, in_ready=0 afterwards.
REQ-036 Load of N=3 with in_valid toggling every other cycle and start pulsed mid-load -> identical writes to continuous case, start ignored, done=1.
REQ-037 rst_n=0 after 2 of 4 data bytes of word 0 -> no write; outputs zero; new start with 00 01 AA BB CC DD -> addr0=0xAABBCCDD.
REQ-038 IM_LOADER_CHECKSUM_EN defined; 00 01 01 02 04 08 then 0F -> done=1; repeat with 0E -> error=1, addr0 still written 0x01020408.

Source files
------------

// File: rtl/im_loader.sv
// Byte-stream program loader: 16-bit BE word count, then BE words into instruction memory.
// Latency: 1 cycle per byte transfer plus 1 WRITE cycle per word; optional checksum byte via IM_LOADER_CHECKSUM_EN.
// Backpressure: in_ready only in header/data/checksum states; gaps in in_valid stall without state change.
module im_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state, state_nxt;
  logic [15:0]       word_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [16:0]       n_hdr;
  logic              last_word;
  logic              restart;

  assign n_hdr     = {1'b0, word_cnt[15:8], in_byte};
  assign last_word = (17'(addr_cnt) + 17'd1) == {1'b0, word_cnt};
  assign restart   = start && (state == IDLE || state == DONE || state == ERR);

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n_hdr == 17'd0)         state_nxt = DONE;
          else if (n_hdr > DEPTH_L)   state_nxt = ERR;
          else                        state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
      CHK: begin
        in_ready = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
        if (in_valid) state_nxt = (csum == in_byte) ? DONE : ERR;
`else
        state_nxt = ERR;
`endif
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = HDR_HI;
      end
      ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_nxt = HDR_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wr_data/wr_addr load on the 4th byte so they are valid throughout WRITE and hold afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      addr_cnt <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (restart) begin
      word_cnt <= '0;
      addr_cnt <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        HDR_HI: if (in_valid) word_cnt[15:8] <= in_byte;
        HDR_LO: if (in_valid) word_cnt[7:0]  <= in_byte;
        DATA: begin
          if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {word_buf[15:0], in_byte};
`ifdef IM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_byte;
`endif
            if (byte_cnt == 2'd3) begin
              wr_data <= {word_buf, in_byte};
              wr_addr <= addr_cnt;
            end
          end
        end
        WRITE: if (!last_word) addr_cnt <= addr_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed scenarios plus randomized loads against a byte-list model.
module tb_im_loader;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready, wr_en, busy, done, error;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          hold_viol = 0;
  logic [9:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  im_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  // Write monitor: records every strobe and flags any address/data movement between strobes
  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = '0;
      last_data = '0;
    end else if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
      last_addr = wr_addr;
      last_data = wr_data;
    end else if (wr_addr !== last_addr || wr_data !== last_data) begin
      hold_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // gap: 0 continuous, 1 toggle every other cycle, 2 random
  task automatic send(input bq_t b, input int gap, input bit mid_start);
    int idx = 0;
    int n = 0;
    while (idx < b.size() && n < 4000) begin
      @(posedge clk); #1;
      start = (mid_start && n == 7);
      case (gap)
        0:       in_valid = 1'b1;
        1:       in_valid = n[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_byte = in_valid ? b[idx] : 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < b.size()) chk("send_timeout", 32'(idx), 32'(b.size()));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic mk_load(input int n, output bq_t b);
    logic [7:0] x;
    b = {};
    x = 8'h00;
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    if (n >= 1 && n <= 1024) begin
      for (int i = 0; i < 4 * n; i++) begin
        b.push_back(8'($urandom));
        x = x ^ b[b.size() - 1];
      end
`ifdef IM_LOADER_CHECKSUM_EN
      b.push_back(x);
`endif
    end
  endtask

  // Expected outcome derived directly from the byte list
  task automatic check_load(input string tag, input bq_t b);
    int  n, nw;
    bit  ok;
    logic [31:0] w;
    n  = int'(b[0]) * 256 + int'(b[1]);
    nw = (n >= 1 && n <= 1024) ? n : 0;
    ok = (n <= 1024);
`ifdef IM_LOADER_CHECKSUM_EN
    if (nw > 0) begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 4 * nw; i++) x = x ^ b[2 + i];
      ok = (x == b[2 + 4 * nw]);
    end
`endif
    chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(nw));
    for (int i = 0; i < nw && i < wq_addr.size(); i++) begin
      w = 32'(int'(b[2+4*i]) * 16777216 + int'(b[3+4*i]) * 65536
            + int'(b[4+4*i]) * 256 + int'(b[5+4*i]));
      chk($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wq_data[i], w);
    end
    chk({tag, "_done"},  {31'd0, done},  {31'd0, ok});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
    chk({tag, "_busy"},  {31'd0, busy},  32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_hold"},  32'(hold_viol), 32'd0);
    wq_addr = {};
    wq_data = {};
    wq_cyc  = {};
  endtask

  initial begin
    bq_t b;
    int  n;

    // Reset state
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_addr",  32'(wr_addr), 32'd0);
    chk("rst_data",  wr_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Two-word continuous load, writes 5 cycles apart
    b = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IM_LOADER_CHECKSUM_EN
    b.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    do_start();
    send(b, 0, 1'b0);
    wait_idle();
    if (wq_cyc.size() == 2) chk("two_word_spacing", 32'(wq_cyc[1] - wq_cyc[0]), 32'd5);
    check_load("two_word", b);

    // Zero-length header: done the cycle after the low header byte
    b = {8'h00, 8'h00};
    do_start();
    send(b, 0, 1'b0);
    chk("zero_done_next", {31'd0, done}, 32'd1);
    wait_idle();
    check_load("zero_len", b);

    // Oversized header
    b = {8'h04, 8'h01};
    do_start();
    send(b, 0, 1'b0);
    wait_idle();
    check_load("oversize", b);

    // Gapped valid with a stray start pulse mid-load
    mk_load(3, b);
    do_start();
    send(b, 1, 1'b1);
    wait_idle();
    check_load("toggle_midstart", b);

    // Reset after two data bytes of word 0
    b = {8'h00, 8'h01, 8'h11, 8'h22};
    do_start();
    send(b, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_addr",  32'(wr_addr), 32'd0);
    chk("midrst_data",  wr_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    chk("midrst_nwrites", 32'(wq_addr.size()), 32'd0);
    b = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IM_LOADER_CHECKSUM_EN
    b.push_back(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
    do_start();
    send(b, 0, 1'b0);
    wait_idle();
    check_load("after_rst", b);

`ifdef IM_LOADER_CHECKSUM_EN
    b = {8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    do_start();
    send(b, 0, 1'b0);
    wait_idle();
    check_load("csum_good", b);
    b = {8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    do_start();
    send(b, 0, 1'b0);
    wait_idle();
    check_load("csum_bad", b);
`endif

    // Randomized loads with random gaps and stray starts
    for (int t = 0; t < 8; t++) begin
      n = (t == 7) ? int'($urandom_range(1025, 65535)) : int'($urandom_range(1, 6));
      mk_load(n, b);
      do_start();
      send(b, 2, 1'($urandom_range(0, 1)));
      wait_idle();
      check_load($sformatf("rand%0d", t), b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
